seg7_mux_driver: RTL and testbench
==================================

Name: seg7_mux_driver

Overview:
Time-multiplexed driver for an N-digit common-anode 7-segment display with a hex-capable decoder per digit. It captures a packed nibble vector and cycles one digit at a time at a programmable refresh rate. Features: per-digit decimal points, leading-zero blanking, inter-digit ghost blanking and tear-free frame-synchronous value updates. Sits between the datapath/register file and the board display pins.

Parameters:
NUM_DIGITS, 4, number of digits/anodes (2..8)
REFRESH_DIV, 50000, clock cycles each digit is selected (>= 2)
BLANK_CYCLES, 500, cycles at start of each digit slot with all anodes off (< REFRESH_DIV)
SEG_ACTIVE_LOW, 1, 1 = seg/dp pins active-low
AN_ACTIVE_LOW, 1, 1 = anode pins active-low

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
enable  in  1  display on; low forces dark outputs and restarts scan
load  in  1  single-cycle strobe capturing value/dp_in
value  in  4*NUM_DIGITS  packed nibbles; digit 0 = bits [3:0]
dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit
blank_lz  in  1  1 = blank leading zero digits
seg  out  7  segments, bit6 = a ... bit0 = g
dp  out  1  decimal point
an  out  NUM_DIGITS  anode selects, one-hot active when lit
digit_idx  out  clog2(NUM_DIGITS)  digit currently scanned
frame_done  out  1  one-cycle pulse at end of each full scan

Behaviour:
- Reset values: all outputs dark (an all inactive, seg/dp off at chosen polarity), digit_idx 0, frame_done 0; prescaler 0; shadow value/dp 0; pending empty.
- Prescaler cnt counts 0..REFRESH_DIV-1 while enable=1. At cnt=REFRESH_DIV-1: cnt->0, idx->idx+1, wrapping NUM_DIGITS-1 -> 0.
- Frame wrap = tick with idx=NUM_DIGITS-1. frame_done pulses high for the cycle after the wrap. Shadow is loaded at wrap, from this cycle's load/value/dp_in if load=1, else from pending if valid. Pending is then cleared.
- load while enable=1 and not at a wrap: value/dp_in go into pending. Later loads overwrite it (last wins).
- load while enable=0: shadow written directly.
- Outputs registered: one-cycle latency from (idx,cnt) to pins. digit_idx mirrors the registered digit.
- Blank window (cnt < BLANK_CYCLES): an all inactive, seg/dp off.
- Otherwise: anode idx active, seg = decode(shadow nibble idx), dp = shadow dp bit idx.
- Leading-zero blank (blank_lz=1): digits above the highest nonzero nibble are dark (anode inactive). Digit 0 is never blanked. A dp on a blanked digit keeps that digit lit with seg off.
- Decode table, active-high abcdefg:
  0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
  Pins are inverted when SEG_ACTIVE_LOW=1.
- enable falling: next cycle outputs dark, cnt and idx forced 0. Scan restarts at digit 0 with a blank window on re-enable.
- rst mid-scan overrides everything, including a pending load.

Decomposition:
- Package seg7_pkg: 16-entry segment pattern constants, SEG_OFF constant, clog2 helper.
- Sub-module hex_to_seg: combinational nibble -> 7-bit active-high pattern. Instantiated once on the muxed nibble; polarity is applied in the top.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1, both polarities active-low unless noted):
- After rst release, enable=1, no load: an=1111 and seg=1111111 for the 1st cycle of each slot. Then an=1110, seg=0000001 ("0") for digit 0. frame_done pulses every 16 cycles.
- Load 16'h12AF, dp_in=4'b0010 with enable=0: digit0 seg=0111000 (F), digit1 seg=0001000 (A) with dp=0, digit2 seg=0010010, digit3 seg=1001111. an sequence 1110, 1101, 1011, 0111.
- Load 16'h3333 mid-frame while showing 16'h12AF: remaining digits of that frame still show 12AF. The frame after frame_done shows 3333. Two loads in one frame: only the last appears.
- blank_lz=1 with 16'h0050: digits 3 and 2 have an inactive, digit1 shows 0100100, digit0 shows 0000001. With 16'h0000, only digit0 is lit.
- Drop enable mid-slot at digit 2: next cycle an=1111, digit_idx=0. Re-enable: blank cycle then digit 0. Repeat with rst instead: pending discarded and shadow reads 0.
- SEG_ACTIVE_LOW=0, AN_ACTIVE_LOW=0, value nibble 8: seg=1111111, an=0001, and dark state is all zeros.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment display driver: decode table, off pattern, width helper.
// Latency: n/a (constants and a constant function only).
// Backpressure: n/a.
package seg7_pkg;

    // All segments unlit, active-high abcdefg (bit6 = a ... bit0 = g).
    localparam logic [6:0] SEG_OFF = 7'b0000000;

    // Hex digit patterns, active-high abcdefg, indexed by nibble value.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b1111110,  // 0
        7'b0110000,  // 1
        7'b1101101,  // 2
        7'b1111001,  // 3
        7'b0110011,  // 4
        7'b1011011,  // 5
        7'b1011111,  // 6
        7'b1110000,  // 7
        7'b1111111,  // 8
        7'b1111011,  // 9
        7'b1110111,  // A
        7'b0011111,  // b
        7'b1001110,  // C
        7'b0111101,  // d
        7'b1001111,  // E
        7'b1000111   // F
    };

    // Bits needed to hold values 0..v-1 (at least 1).
    function automatic int seg7_clog2(input int v);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Nibble to 7-segment pattern decoder (hex-capable), active-high abcdefg.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the input nibble.
module hex_to_seg
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] pat
);

    assign pat = SEG_TABLE[nib];

endmodule

// File: rtl/seg7_mux_driver.sv
// Time-multiplexed N-digit 7-segment driver with LZ blanking, ghost blanking and frame-synced updates.
// Latency: pins are registered one cycle after the scan position (idx,cnt); loads show from the next frame.
// Backpressure: none; loads are never refused, the last load before a frame wrap wins.
module seg7_mux_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int BLANK_CYCLES   = 500,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 enable,
    input  logic                                 load,
    input  logic [4*NUM_DIGITS-1:0]              value,
    input  logic [NUM_DIGITS-1:0]                dp_in,
    input  logic                                 blank_lz,
    output logic [6:0]                           seg,
    output logic                                 dp,
    output logic [NUM_DIGITS-1:0]                an,
    output logic [seg7_clog2(NUM_DIGITS)-1:0]    digit_idx,
    output logic                                 frame_done
);

    localparam int IW = seg7_clog2(NUM_DIGITS);
    localparam int CW = seg7_clog2(REFRESH_DIV);

    // XOR masks converting active-high internal levels to pin polarity.
    localparam logic [NUM_DIGITS-1:0] AN_INV  = AN_ACTIVE_LOW  ? '1 : '0;
    localparam logic [6:0]            SEG_INV = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic                  DP_INV  = SEG_ACTIVE_LOW;

    logic [CW-1:0]             cnt;
    logic [IW-1:0]             idx;
    logic [4*NUM_DIGITS-1:0]   shadow_val;
    logic [NUM_DIGITS-1:0]     shadow_dp;
    logic [4*NUM_DIGITS-1:0]   pend_val;
    logic [NUM_DIGITS-1:0]     pend_dp;
    logic                      pend_vld;

    logic                      tick;
    logic                      last_digit;
    logic                      wrap;
    logic                      in_blank;
    logic [3:0]                cur_nib;
    logic                      cur_dp;
    logic [6:0]                dec_pat;
    logic [IW-1:0]             hi_digit;
    logic                      lz_dark;
    logic [NUM_DIGITS-1:0]     sel;
    logic [NUM_DIGITS-1:0]     nxt_an;
    logic [6:0]                nxt_seg;
    logic                      nxt_dp;

    assign tick       = (cnt == CW'(REFRESH_DIV - 1));
    assign last_digit = (idx == IW'(NUM_DIGITS - 1));
    assign wrap       = enable && tick && last_digit;
    assign in_blank   = (cnt < CW'(BLANK_CYCLES));
    assign cur_nib    = shadow_val[{idx, 2'b00} +: 4];
    assign cur_dp     = shadow_dp[idx];
    assign sel        = NUM_DIGITS'(1) << idx;
    assign lz_dark    = blank_lz && (idx > hi_digit);

    hex_to_seg u_dec (
        .nib (cur_nib),
        .pat (dec_pat)
    );

    // Prescaler and digit pointer; disabling parks the scan at digit 0, count 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (!enable) begin
            cnt <= '0;
            idx <= '0;
        end else if (tick) begin
            cnt <= '0;
            idx <= last_digit ? '0 : idx + IW'(1);
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Shadow/pending capture: shadow only changes at a frame wrap while scanning, so a frame never tears.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_val <= '0;
            shadow_dp  <= '0;
            pend_val   <= '0;
            pend_dp    <= '0;
            pend_vld   <= 1'b0;
        end else if (!enable) begin
            // Display is dark, nothing to tear: write straight through and drop any stale pending value.
            if (load) begin
                shadow_val <= value;
                shadow_dp  <= dp_in;
                pend_vld   <= 1'b0;
            end
        end else if (wrap) begin
            if (load) begin
                shadow_val <= value;
                shadow_dp  <= dp_in;
            end else if (pend_vld) begin
                shadow_val <= pend_val;
                shadow_dp  <= pend_dp;
            end
            pend_vld <= 1'b0;
        end else if (load) begin
            pend_val <= value;
            pend_dp  <= dp_in;
            pend_vld <= 1'b1;
        end
    end

    // Highest nonzero digit; digit 0 is the floor so it is never treated as a leading zero.
    always_comb begin
        hi_digit = '0;
        for (int d = 1; d < NUM_DIGITS; d++) begin
            if (shadow_val[4*d +: 4] != 4'h0) hi_digit = IW'(d);
        end
    end

    // Active-high pin levels for the current scan position.
    always_comb begin
        nxt_an  = '0;
        nxt_seg = SEG_OFF;
        nxt_dp  = 1'b0;
        if (enable && !in_blank) begin
            if (!lz_dark) begin
                nxt_an  = sel;
                nxt_seg = dec_pat;
                nxt_dp  = cur_dp;
            end else if (cur_dp) begin
                // A lit decimal point keeps a blanked leading digit powered with segments off.
                nxt_an = sel;
                nxt_dp = 1'b1;
            end
        end
    end

    // Output registers at pin polarity.
    always_ff @(posedge clk) begin
        if (rst) begin
            an         <= AN_INV;
            seg        <= SEG_OFF ^ SEG_INV;
            dp         <= DP_INV;
            digit_idx  <= '0;
            frame_done <= 1'b0;
        end else begin
            an         <= nxt_an ^ AN_INV;
            seg        <= nxt_seg ^ SEG_INV;
            dp         <= nxt_dp ^ DP_INV;
            digit_idx  <= enable ? idx : '0;
            frame_done <= wrap;
        end
    end

endmodule

// File: tb/tb_seg7_mux_driver.sv
// Self-checking bench for seg7_mux_driver with a per-cycle expected-output scoreboard.
// Latency: expected frames assume one registered cycle from scan position to pins.
// Backpressure: n/a.
module tb_seg7_mux_driver;

    typedef logic [14:0] obs_t;  // {an, seg, dp, digit_idx, frame_done}

    logic        clk = 1'b0;
    logic        rst, enable, load, blank_lz;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic [1:0]  digit_idx;
    logic        frame_done;

    logic        enable_h, load_h;
    logic [15:0] value_h;
    logic [6:0]  seg_h;
    logic        dp_h;
    logic [3:0]  an_h;
    logic [1:0]  idx_h;
    logic        fd_h;

    obs_t q[$];
    obs_t qh[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    seg7_mux_driver #(
        .NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1),
        .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
    ) u_dut (
        .clk(clk), .rst(rst), .enable(enable), .load(load), .value(value),
        .dp_in(dp_in), .blank_lz(blank_lz), .seg(seg), .dp(dp), .an(an),
        .digit_idx(digit_idx), .frame_done(frame_done)
    );

    seg7_mux_driver #(
        .NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1),
        .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)
    ) u_dut_hi (
        .clk(clk), .rst(rst), .enable(enable_h), .load(load_h), .value(value_h),
        .dp_in(4'b0000), .blank_lz(1'b0), .seg(seg_h), .dp(dp_h), .an(an_h),
        .digit_idx(idx_h), .frame_done(fd_h)
    );

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1111110;
            4'h1: return 7'b0110000;
            4'h2: return 7'b1101101;
            4'h3: return 7'b1111001;
            4'h4: return 7'b0110011;
            4'h5: return 7'b1011011;
            4'h6: return 7'b1011111;
            4'h7: return 7'b1110000;
            4'h8: return 7'b1111111;
            4'h9: return 7'b1111011;
            4'hA: return 7'b1110111;
            4'hB: return 7'b0011111;
            4'hC: return 7'b1001110;
            4'hD: return 7'b0111101;
            4'hE: return 7'b1001111;
            default: return 7'b1000111;
        endcase
    endfunction

    // Expected active-low pins for cycle i (0..15) of a frame following a frame_done cycle.
    function automatic obs_t exp_entry(input logic [15:0] v, input logic [3:0] d,
                                       input logic lz, input int i);
        int         slot = i / 4;
        int         c    = i % 4;
        int         hi   = 0;
        logic [3:0] oh;
        logic [3:0] an_e;
        logic [6:0] seg_e;
        logic       dp_e;
        oh    = 4'b0001 << slot;
        an_e  = 4'b1111;
        seg_e = 7'b1111111;
        dp_e  = 1'b1;
        for (int k = 1; k < 4; k++) begin
            if (v[k*4 +: 4] != 4'h0) hi = k;
        end
        if (c != 0) begin
            if (lz && slot > hi) begin
                if (d[slot]) begin
                    an_e = ~oh;
                    dp_e = 1'b0;
                end
            end else begin
                an_e  = ~oh;
                seg_e = ~seg_of(v[slot*4 +: 4]);
                dp_e  = ~d[slot];
            end
        end
        return {an_e, seg_e, dp_e, 2'(slot), (i == 15)};
    endfunction

    // Expected active-high pins for the second instance showing nibble 8 everywhere.
    function automatic obs_t exp_hi(input int i);
        int slot = i / 4;
        logic [3:0] oh;
        oh = 4'b0001 << slot;
        if (i % 4 == 0) return {4'b0000, 7'b0000000, 1'b0, 2'(slot), (i == 15)};
        return {oh, 7'b1111111, 1'b0, 2'(slot), (i == 15)};
    endfunction

    task automatic push_frame(input logic [15:0] v, input logic [3:0] d, input logic lz,
                              input int first, input int last);
        for (int i = first; i <= last; i++) q.push_back(exp_entry(v, d, lz, i));
    endtask

    task automatic push_dark();
        q.push_back({4'b1111, 7'b1111111, 1'b1, 2'b00, 1'b0});
    endtask

    task automatic run_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (q.size() > 0) begin
                obs_t e = q.pop_front();
                obs_t o = {an, seg, dp, digit_idx, frame_done};
                total++;
                assert (o === e) else begin
                    bad++;
                    $error("FAIL main_pins t=%0t got=%b want=%b", $time, o, e);
                end
            end
            if (qh.size() > 0) begin
                obs_t eh = qh.pop_front();
                obs_t oh = {an_h, seg_h, dp_h, idx_h, fd_h};
                total++;
                assert (oh === eh) else begin
                    bad++;
                    $error("FAIL hi_pins t=%0t got=%b want=%b", $time, oh, eh);
                end
            end
        end
    endtask

    task automatic pulse_load(input logic [15:0] v, input logic [3:0] d);
        value = v;
        dp_in = d;
        load  = 1'b1;
        run_cycles(1);
        load  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; load = 1'b0; value = '0; dp_in = '0; blank_lz = 1'b0;
        enable_h = 1'b0; load_h = 1'b0; value_h = '0;

        // Reset: both instances dark at their own polarity.
        push_dark(); push_dark();
        qh.push_back('0); qh.push_back('0);
        run_cycles(2);

        // Free-running scan of a zero shadow, two frames, frame_done every 16 cycles.
        rst = 1'b0;
        push_frame(16'h0000, 4'b0000, 1'b0, 0, 15);
        push_frame(16'h0000, 4'b0000, 1'b0, 0, 15);
        run_cycles(32);

        // Direct load while disabled, then a full frame from digit 0.
        value = 16'h12AF; dp_in = 4'b0010; enable = 1'b0; load = 1'b1;
        push_dark();
        run_cycles(1);
        load = 1'b0; enable = 1'b1;
        push_frame(16'h12AF, 4'b0010, 1'b0, 0, 15);
        run_cycles(16);

        // Mid-frame load must not tear the current frame.
        push_frame(16'h12AF, 4'b0010, 1'b0, 0, 15);
        run_cycles(5);
        pulse_load(16'h3333, 4'b0000);
        run_cycles(10);

        // Two loads in one frame: last one wins.
        push_frame(16'h3333, 4'b0000, 1'b0, 0, 15);
        run_cycles(3);
        pulse_load(16'h1111, 4'b1111);
        run_cycles(4);
        pulse_load(16'h4567, 4'b0001);
        run_cycles(7);

        // Load sampled exactly on the wrap edge lands in the very next frame.
        push_frame(16'h4567, 4'b0001, 1'b0, 0, 15);
        run_cycles(15);
        pulse_load(16'hBCDE, 4'b1000);

        push_frame(16'hBCDE, 4'b1000, 1'b0, 0, 15);
        run_cycles(5);
        pulse_load(16'h0050, 4'b0000);
        run_cycles(10);

        // Leading-zero blanking, including a dp on a blanked digit.
        blank_lz = 1'b1;
        push_frame(16'h0050, 4'b0000, 1'b1, 0, 15);
        run_cycles(5);
        pulse_load(16'h0000, 4'b0100);
        run_cycles(10);

        push_frame(16'h0000, 4'b0100, 1'b1, 0, 15);
        run_cycles(5);
        pulse_load(16'h0000, 4'b0000);
        run_cycles(10);

        push_frame(16'h0000, 4'b0000, 1'b1, 0, 15);
        run_cycles(16);

        // Drop enable while digit 2 is lit, then restart from digit 0.
        push_frame(16'h0000, 4'b0000, 1'b1, 0, 9);
        run_cycles(10);
        enable = 1'b0;
        push_dark();
        run_cycles(1);
        enable = 1'b1;
        push_frame(16'h0000, 4'b0000, 1'b1, 0, 15);
        run_cycles(16);

        // Reset mid-frame discards a pending load and clears the shadow.
        blank_lz = 1'b0;
        push_frame(16'h0000, 4'b0000, 1'b0, 0, 15);
        run_cycles(5);
        pulse_load(16'h7777, 4'b1010);
        run_cycles(10);
        push_frame(16'h7777, 4'b1010, 1'b0, 0, 5);
        run_cycles(5);
        pulse_load(16'h9999, 4'b1111);
        rst = 1'b1;
        push_dark();
        run_cycles(1);
        rst = 1'b0;
        push_frame(16'h0000, 4'b0000, 1'b0, 0, 15);
        push_frame(16'h0000, 4'b0000, 1'b0, 0, 15);
        run_cycles(32);

        // Active-high pin polarity instance: dark is all zeros, nibble 8 lights every segment.
        value_h = 16'h8888; load_h = 1'b1;
        qh.push_back('0);
        run_cycles(1);
        load_h = 1'b0; enable_h = 1'b1;
        for (int i = 0; i < 16; i++) qh.push_back(exp_hi(i));
        run_cycles(16);

        total++;
        assert (q.size() == 0 && qh.size() == 0) else begin
            bad++;
            $error("FAIL scoreboard_drain got=%0d/%0d want=0/0", q.size(), qh.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
